// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin, packet-locked scheduler sharing one
// 8N1 UART tx core among N_REQ byte sources.
//
// Ports:
//   clk, res              clock, synchronous active-high reset
//   req_valid/data/last   per-requester byte stream (byte i at [8i+7:8i])
//   req_ready             byte accepted on valid&ready at a clk edge
//   tx_start/tx_data      start pulse and byte to the tx core
//   tx_busy               tx core busy (rises after start, falls after stop)
//   grant_id, active      current/last grant, grant held
//   err                   one-cycle pulse on ack or lock timeout
module uart_tx_sched #(
  parameter int N_REQ        = 2,
  parameter int GAP_CYCLES   = 0,
  parameter int ACK_TIMEOUT  = 16,
  parameter int LOCK_TIMEOUT = 1000000,
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               res,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  output logic [GW-1:0]      grant_id,
  output logic               active,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_q, rr_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          last_q, last_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          active_q, active_d;
  logic          err_q, err_d;

  logic [GW-1:0] pick;
  logic          found;
  logic [GW-1:0] g_next;
  logic          g_valid;
  logic          accept;
  logic          post;
  logic [7:0]    g_byte;

  // First valid requester at or after the rr pointer, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      int idx;
      idx = (int'(rr_q) + i) % N_REQ;
      if (!found && req_valid[GW'(idx)]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  assign g_next = (grant_q == GW'(N_REQ - 1)) ? '0
                                              : grant_q + 1'b1;
  assign g_valid = req_valid[grant_q];
  assign g_byte  = req_data[{grant_q, 3'b000} +: 8];
  assign accept  = (state_q == S_FETCH) && g_valid && !tx_busy;

  always_comb begin
    req_ready = '0;
    if (state_q == S_FETCH)
      req_ready[grant_q] = g_valid & ~tx_busy;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    tx_data_d = tx_data_q;
    err_d     = 1'b0;
    post      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (accept) begin
          tx_data_d = g_byte;
          last_d    = req_last[grant_q];
          cnt_d     = '0;
          state_d   = S_START;
        end else if (cnt_q == 32'(LOCK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rr_d    = g_next;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_START: begin
        // The start cycle itself counts toward the ack timeout.
        cnt_d   = 32'd1;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q >= 32'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rr_d    = g_next;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (GAP_CYCLES > 0) begin
            cnt_d   = '0;
            state_d = S_GAP;
          end else begin
            post = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == 32'(GAP_CYCLES - 1))
          post = 1'b1;
        else
          cnt_d = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (post) begin
      cnt_d = '0;
      if (last_q) begin
        rr_d    = g_next;
        state_d = S_IDLE;
      end else begin
        state_d = S_FETCH;
      end
    end
  end

  assign tx_start_d = (state_d == S_START);
  assign active_d   = (state_d != S_IDLE);

  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      active_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      active_q   <= active_d;
      err_q      <= err_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_q;
  assign active   = active_q;
  assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scoreboard bench for uart_tx_sched with a
// behavioural tx core model and two queued byte sources.
module tb_uart_tx_sched;

  localparam int N    = 2;
  localparam int GAP  = 3;
  localparam int ACK  = 16;
  localparam int LOCK = 200;
  localparam int BUSY = 20;

  logic         clk = 1'b0;
  logic         res = 1'b1;
  logic [1:0]   req_valid = '0;
  logic [15:0]  req_data = '0;
  logic [1:0]   req_last = '0;
  logic [1:0]   req_ready;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic         tx_busy = 1'b0;
  logic [0:0]   grant_id;
  logic         active;
  logic         err;

  always #5 clk = ~clk;

  uart_tx_sched #(
    .N_REQ(N),
    .GAP_CYCLES(GAP),
    .ACK_TIMEOUT(ACK),
    .LOCK_TIMEOUT(LOCK)
  ) dut (
    .clk(clk),
    .res(res),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .grant_id(grant_id),
    .active(active),
    .err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  logic [8:0] src0[$];
  logic [8:0] src1[$];
  logic [8:0] sb[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic core_dead = 1'b0;
  int   fall_cyc = 0;
  int   start_cnt = 0;
  int   start_cyc = 0;
  int   last_gap = 0;
  int   err_cnt = 0;
  int   err_cyc = 0;
  logic err_active = 1'b0;
  int   coinc = 0;
  int   rdy0_cnt = 0;
  int   rdy1_bad = 0;
  logic lockwin = 1'b0;

  task automatic drive();
    req_valid[0] = (src0.size() != 0);
    req_valid[1] = (src1.size() != 0);
    req_data = '0;
    req_last = '0;
    if (src0.size() != 0) begin
      req_data[7:0] = src0[0][7:0];
      req_last[0]   = src0[0][8];
    end
    if (src1.size() != 0) begin
      req_data[15:8] = src1[0][7:0];
      req_last[1]    = src1[0][8];
    end
  endtask

  // Byte sources: pop on a handshake seen at the edge, re-drive after it.
  initial begin
    logic [1:0] acc;
    logic [8:0] tmp;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (acc[0]) tmp = src0.pop_front();
      if (acc[1]) tmp = src1.pop_front();
      drive();
    end
  end

  // Tx core model: busy two clocks after start, held BUSY clocks.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start && !core_dead) begin
        repeat (2) @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (BUSY) @(posedge clk);
        #1 tx_busy = 1'b0;
        fall_cyc = cyc;
      end
    end
  end

  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (req_ready[0]) rdy0_cnt++;
      if (req_ready[1] && lockwin) rdy1_bad++;
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
        err_active = active;
        if (tx_start) coinc++;
      end
      if (tx_start) begin
        start_cnt++;
        start_cyc = cyc;
        last_gap = cyc - fall_cyc;
        if (sb.size() == 0) begin
          chk("sb_extra", 32'(tx_data), 32'hFFFF);
        end else begin
          e = sb.pop_front();
          chk("sb_data", 32'(tx_data), 32'(e[7:0]));
          chk("sb_id", 32'(grant_id), 32'(e[8]));
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    res = 1'b1;
    repeat (2) @(posedge clk);
    #1 res = 1'b0;
    @(negedge clk);
    chk("rst_start", 32'(tx_start), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ready", 32'(req_ready), 0);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (!(sb.size() == 0 && !active && !tx_busy &&
             src0.size() == 0 && src1.size() == 0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) chk("idle_tmo", 32'(k), 0);
  endtask

  task automatic wait_start(input int n);
    int k;
    k = 0;
    while (start_cnt < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) chk("start_tmo", 32'(start_cnt), 32'(n));
  endtask

  task automatic wait_err(input int n);
    int k;
    k = 0;
    while (err_cnt < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) chk("err_tmo", 32'(err_cnt), 32'(n));
  endtask

  task automatic wait_busy(input logic v);
    int k;
    k = 0;
    while (tx_busy !== v && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) chk("busy_tmo", 32'(tx_busy), 32'(v));
  endtask

  initial begin
    int n0;
    int e0;
    int push_cyc;

    // T1: single byte, latency and one-cycle ready.
    do_reset();
    rdy0_cnt = 0;
    n0 = start_cnt;
    push_cyc = cyc;
    src0.push_back({1'b1, 8'hA5});
    sb.push_back({1'b0, 8'hA5});
    wait_start(n0 + 1);
    chk("t1_lat", 32'(start_cyc - push_cyc), 3);
    wait_idle();
    chk("t1_rdy0", 32'(rdy0_cnt), 1);
    chk("t1_starts", 32'(start_cnt - n0), 1);

    // T2: two contending single-byte sources alternate.
    do_reset();
    n0 = start_cnt;
    for (int i = 0; i < 3; i++) begin
      src0.push_back({1'b1, 8'h11});
      src1.push_back({1'b1, 8'h22});
      sb.push_back({1'b0, 8'h11});
      sb.push_back({1'b1, 8'h22});
    end
    wait_idle();
    chk("t2_starts", 32'(start_cnt - n0), 6);

    // T3: packet lock holds off the other requester.
    do_reset();
    n0 = start_cnt;
    rdy1_bad = 0;
    lockwin = 1'b1;
    src0.push_back({1'b0, 8'h01});
    src0.push_back({1'b0, 8'h02});
    src0.push_back({1'b1, 8'h03});
    src1.push_back({1'b1, 8'h44});
    sb.push_back({1'b0, 8'h01});
    sb.push_back({1'b0, 8'h02});
    sb.push_back({1'b0, 8'h03});
    sb.push_back({1'b1, 8'h44});
    wait_start(n0 + 3);
    wait_busy(1'b1);
    wait_busy(1'b0);
    lockwin = 1'b0;
    wait_idle();
    chk("t3_rdy1_locked", 32'(rdy1_bad), 0);

    // T4: inter-frame gap inside a packet.
    do_reset();
    src0.push_back({1'b0, 8'h55});
    src0.push_back({1'b1, 8'h66});
    sb.push_back({1'b0, 8'h55});
    sb.push_back({1'b0, 8'h66});
    wait_idle();
    chk("t4_gap", 32'(last_gap), 5);

    // T5: core never acknowledges.
    do_reset();
    n0 = start_cnt;
    e0 = err_cnt;
    core_dead = 1'b1;
    src0.push_back({1'b1, 8'h77});
    src1.push_back({1'b1, 8'h88});
    sb.push_back({1'b0, 8'h77});
    sb.push_back({1'b1, 8'h88});
    wait_start(n0 + 1);
    wait_err(e0 + 1);
    core_dead = 1'b0;
    chk("t5_err_dly", 32'(err_cyc - start_cyc), 16);
    chk("t5_active", 32'(err_active), 0);
    wait_idle();
    chk("t5_errs", 32'(err_cnt - e0), 1);

    // T6: reset mid-frame clears the rr pointer.
    do_reset();
    n0 = start_cnt;
    src0.push_back({1'b1, 8'hE0});
    sb.push_back({1'b0, 8'hE0});
    wait_busy(1'b1);
    repeat (3) @(negedge clk);
    src0.push_back({1'b1, 8'hC0});
    src1.push_back({1'b1, 8'hB2});
    @(negedge clk);
    res = 1'b1;
    @(posedge clk);
    #1 res = 1'b0;
    @(negedge clk);
    chk("t6_start", 32'(tx_start), 0);
    chk("t6_data", 32'(tx_data), 0);
    chk("t6_grant", 32'(grant_id), 0);
    chk("t6_active", 32'(active), 0);
    chk("t6_err", 32'(err), 0);
    chk("t6_ready", 32'(req_ready), 0);
    chk("t6_busy_kept", 32'(tx_busy), 1);
    sb.push_back({1'b0, 8'hC0});
    sb.push_back({1'b1, 8'hB2});
    wait_idle();
    chk("t6_starts", 32'(start_cnt - n0), 3);

    chk("sb_empty", 32'(sb.size()), 0);
    chk("err_vs_start", 32'(coinc), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
